// File: rtl/taint_sum_monitor.sv
// Global taint monitor: sums taint_sum buses, latches first taint,
// and streams per-source change records to the simulation logger.
module taint_sum_monitor #(
  parameter int N_SRC      = 8,
  parameter int SUM_W      = 16,
  parameter int CNT_W      = 32,
  parameter int FIFO_DEPTH = 8,
  localparam int IDX_W     = $clog2(N_SRC),
  localparam int TOT_W     = SUM_W + IDX_W
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   clear,
  input  logic [N_SRC*SUM_W-1:0] src_sum,
  output logic [TOT_W-1:0]       total_taint,
  output logic                   any_taint,
  output logic                   first_valid,
  output logic [CNT_W-1:0]       first_cycle,
  output logic                   rec_valid,
  input  logic                   rec_ready,
  output logic [CNT_W-1:0]       rec_cycle,
  output logic [IDX_W-1:0]       rec_src,
  output logic [SUM_W-1:0]       rec_value,
  output logic [15:0]            stall_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [SUM_W-1:0] slot [N_SRC];
  logic [SUM_W-1:0] shadow [N_SRC];
  logic [TOT_W-1:0] sum;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] ptr;
  logic [SUM_W-1:0] cur;
  logic             changed;
  logic             full;
  logic             pop;
  logic             push;
  logic             stall;

  logic [CNT_W-1:0] mem_cycle [FIFO_DEPTH];
  logic [IDX_W-1:0] mem_src [FIFO_DEPTH];
  logic [SUM_W-1:0] mem_value [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  // Unknown slots count as zero everywhere downstream
  for (genvar g = 0; g < N_SRC; g++) begin : g_slot
    assign slot[g] = $isunknown(src_sum[g*SUM_W +: SUM_W])
                   ? '0 : src_sum[g*SUM_W +: SUM_W];
  end

  // Full-width sum of all slots
  always_comb begin
    sum = '0;
    for (int i = 0; i < N_SRC; i++)
      sum = sum + TOT_W'(slot[i]);
  end

  assign cur     = slot[ptr];
  assign changed = cur != shadow[ptr];
  assign full    = count == (PTR_W+1)'(FIFO_DEPTH);
  assign pop     = rec_valid & rec_ready;
  assign push    = en & changed & (~full | pop);
  assign stall   = en & changed & full & ~pop;

  assign any_taint = total_taint != '0;
  assign rec_valid = count != '0;
  assign rec_cycle = rec_valid ? mem_cycle[rd_ptr] : '0;
  assign rec_src   = rec_valid ? mem_src[rd_ptr] : '0;
  assign rec_value = rec_valid ? mem_value[rd_ptr] : '0;

  // Cycle counter, runs only while monitoring
  always_ff @(posedge clock or posedge reset) begin
    if (reset)      cnt <= '0;
    else if (clear) cnt <= '0;
    else if (en)    cnt <= cnt + 1'b1;
  end

  // Registered global total, tracked regardless of enable
  always_ff @(posedge clock or posedge reset) begin
    if (reset)      total_taint <= '0;
    else if (clear) total_taint <= '0;
    else            total_taint <= sum;
  end

  // Latch the counter value when taint first shows up
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      first_valid <= 1'b0;
      first_cycle <= '0;
    end else if (clear) begin
      first_valid <= 1'b0;
      first_cycle <= '0;
    end else if (en && !first_valid && sum != '0) begin
      first_valid <= 1'b1;
      first_cycle <= cnt;
    end
  end

  // Round-robin scan: shadows follow accepted reports only
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr       <= '0;
      stall_cnt <= '0;
      for (int i = 0; i < N_SRC; i++) shadow[i] <= '0;
    end else if (clear) begin
      ptr       <= '0;
      stall_cnt <= '0;
      for (int i = 0; i < N_SRC; i++) shadow[i] <= '0;
    end else if (en) begin
      ptr <= ptr + 1'b1;
      if (push) shadow[ptr] <= cur;
      if (stall && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

  // Record FIFO, first-word fall-through, drains independent of en
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_cycle[i] <= '0;
        mem_src[i]   <= '0;
        mem_value[i] <= '0;
      end
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem_cycle[wr_ptr] <= cnt;
        mem_src[wr_ptr]   <= ptr;
        mem_value[wr_ptr] <= cur;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/taint_sum_monitor.md
Name: taint_sum_monitor

Overview:
- Consumer side of the taint-cell taint_sum outputs.
- Samples N_SRC taint_sum buses from taint cells (registers and memories) and keeps a registered global taint total.
- Latches the first cycle at which any taint appears.
- Streams per-source change records (cycle, source index, new value) over a valid/ready port to the simulation logger.
- Sits beside SOC_TOP in the simulation harness; not synthesised into the SoC.

Parameters:
N_SRC, 8, number of monitored taint_sum sources (>=2, power of two)
SUM_W, 16, width of each source slot; narrower taint_sum values are zero-extended by the harness
CNT_W, 32, width of the cycle counter and record timestamp
FIFO_DEPTH, 8, record FIFO entries (power of two, >=2)

Ports:
clock  in  1  sampling clock, rising edge
reset  in  1  asynchronous, active-high reset
en  in  1  monitoring enable
clear  in  1  synchronous soft clear; has priority over en
src_sum  in  N_SRC*SUM_W  source i occupies bits [i*SUM_W +: SUM_W]
total_taint  out  SUM_W+log2(N_SRC)  registered sum of all sources
any_taint  out  1  total_taint != 0
first_valid  out  1  first taint latched
first_cycle  out  CNT_W  cycle counter value when total first became nonzero
rec_valid  out  1  record available
rec_ready  in  1  consumer accepts record
rec_cycle  out  CNT_W  record timestamp
rec_src  out  log2(N_SRC)  record source index
rec_value  out  SUM_W  record new value
stall_cnt  out  16  cycles a pending change was blocked by a full FIFO; saturates at 0xFFFF

Behaviour:
- Reset (async, or clear at a rising edge): all outputs 0; cycle counter, shadow registers, scan pointer, FIFO, first latch and stall_cnt set to 0.
- Cycle counter: increments at each rising edge with en=1 and clear=0; wraps modulo 2^CNT_W; holds when en=0.
- total_taint(t+1) = sum of all src_sum slots at t, computed at full width so it cannot overflow. Updated every cycle regardless of en.
- First-taint latch:
  - At an edge with en=1, first_valid=0 and a nonzero combinational sum: set first_valid=1 and first_cycle = current counter value (pre-increment).
  - Once set, holds until clear or reset.
- Scan FSM:
  - States: IDLE (en=0) and SCAN (en=1).
  - In SCAN, pointer p is examined each cycle and advances p -> p+1 mod N_SRC every SCAN cycle, whether or not a push happens.
  - If src_sum[p] != shadow[p] and the FIFO is not full: push {counter, p, src_sum[p]} and set shadow[p] = src_sum[p].
  - If src_sum[p] != shadow[p] and the FIFO is full: no push, shadow unchanged, stall_cnt++ (saturating). The change is retried on a later pass; only the latest value is ever reported, never lost.
  - Worst-case report latency with a non-full FIFO: N_SRC cycles.
  - In IDLE the pointer and shadows hold.
- FIFO:
  - Registered output: a record pushed at edge t is visible with rec_valid=1 after edge t (first-word fall-through).
  - Pop when rec_valid & rec_ready.
  - Push and pop in the same cycle while full: the pop frees the slot, the push is accepted and no stall is counted.
  - Full means FIFO_DEPTH entries.
  - Order is preserved.
  - rec_cycle, rec_src and rec_value hold while rec_valid=1 and rec_ready=0.
  - Drains regardless of en.
- clear during a pending rec_valid: FIFO flushed, rec_valid=0 next cycle, no partial record.
- X on src_sum: the slot is treated as 0 for the sum, the comparison and the record.

Test Plan:
- Reset only, en=1, all src_sum=0 for 20 cycles -> rec_valid never 1; any_taint=0; first_valid=0; counter=20.
- en=1 from cycle 0, src 3 set to 5 before edge 0 -> total_taint=5 after edge 0; first_valid=1, first_cycle=0; one record {cycle=3, src=3, value=5} visible after edge 3.
- src 1=2 and src 6=7 change at the same edge, rec_ready=1 -> two records in scan order: src 1 first, then src 6; timestamps differ by 5.
- rec_ready=0 and all 8 sources change repeatedly -> exactly 8 records queued; stall_cnt increments on each blocked check. Then set rec_ready=1 -> the latest values are reported afterwards, with no duplicate of an unchanged value.
- Assert clear while 3 records are pending -> rec_valid=0 next cycle; first_valid=0; counter=0; nonzero sources are re-reported from pointer 0.
- Assert async reset mid-cycle while rec_valid=1 -> outputs 0 immediately, without waiting for a clock edge.
